golden_nonce_queue: RTL
=======================

Name: golden_nonce_queue

Overview:
- Downstream of the hash core. Captures every one-cycle golden-nonce match strobe and its nonce into a small FIFO.
- Presents queued nonces to the host-readout logic (USB/serial) over a first-word-fall-through valid/ack interface.
- Prevents loss of back-to-back matches while the host is slow to poll.
- Tracks dropped results in a saturating overflow counter.

Parameters:
- DEPTH, 8, number of nonce entries; must be a power of 2, minimum 2.
- AW, 3, address width; must equal log2(DEPTH).

Ports:
- hash_clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- match_in  input  1  one-cycle match strobe from the hash core.
- nonce_in  input  32  golden nonce; valid in the cycle match_in=1.
- out_valid  output  1  head entry is available (queue not empty).
- out_nonce  output  32  head nonce; valid while out_valid=1.
- out_ack  input  1  host consumed the head; pops the entry when out_valid=1.
- count  output  AW+1  number of entries held, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow_cnt  output  8  saturating count of matches dropped because the queue was full.

Behaviour:
- Reset: synchronous on hash_clk, active-high.
  - Write pointer, read pointer, count and overflow_cnt go to 0.
  - out_valid=0, full=0, out_nonce=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries. A match_in asserted in the same cycle as reset is discarded.
- Push: match_in=1 and (full=0 or a pop occurs in the same cycle).
  - nonce_in is written at the write pointer, which then increments modulo DEPTH.
- Pop: out_ack=1 and out_valid=1.
  - Read pointer increments modulo DEPTH.
  - out_ack while out_valid=0 is ignored; no pointer movement and no error.
- Latency: a nonce pushed at edge N gives out_valid=1 and out_nonce=that value after edge N (visible in cycle N+1) when the queue was empty.
- Output timing:
  - out_nonce is registered, first-word-fall-through.
  - After a pop, the next entry appears the cycle after the ack edge.
  - No bubble when entries remain.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Simultaneous push and pop while full: both are performed; the push is accepted and overflow_cnt is unchanged.
- Simultaneous push and pop while empty: the pop is ignored (out_valid was 0); the push is accepted and count becomes 1.
- Full and match_in without a pop: nonce dropped; overflow_cnt increments, saturating at 255 (never wraps).
- Pointer wrap: pointers are AW bits and wrap DEPTH-1 to 0. Full and empty are derived from count, not from pointer equality.
- full and out_valid are registered alongside count, with no combinational path from inputs.
- FIFO order is strictly preserved.

Optional Feature:
- Macro: GNQ_DEDUP_EN.
- Defined:
  - Holds last_nonce[31:0] plus a last_valid flag; both are cleared by reset.
  - A match whose nonce_in equals last_nonce while last_valid=1 is dropped silently: no push, no overflow_cnt increment.
  - Every accepted push updates last_nonce and sets last_valid.
  - Drops caused by full also update last_nonce.
  - Purpose: suppresses repeated strobes carrying the same nonce.
- Not defined: every match is queued subject only to capacity; no extra registers.

Test Plan:
1. Reset, then single match_in with nonce_in=0x12345678, out_ack held 0.
   -> Next cycle out_valid=1, out_nonce=0x12345678, count=1. Pulse out_ack -> next cycle out_valid=0, count=0.
2. 8 consecutive match strobes with nonces 0x10..0x17, no ack.
   -> full=1, count=8. A 9th match 0x18 -> overflow_cnt=1, count=8. Drain 8 acks -> reads 0x10..0x17 in order.
3. Full queue, match 0x99 with out_ack=1 in the same cycle.
   -> 0x10 popped, 0x99 accepted, count stays 8, overflow_cnt unchanged. 0x99 is read last.
4. 300 matches into a full queue with no acks.
   -> overflow_cnt=255, no wrap. Reset -> overflow_cnt=0, out_valid=0, count=0.
5. Pointer wrap: 20 push/pop cycles at 1 entry in flight with nonces 0xA0..0xB3.
   -> Each read equals the corresponding write. count never exceeds 1; out_ack while empty has no effect.
6. GNQ_DEDUP_EN defined: matches 0x55, 0x55, 0x56, 0x55.
   -> Queue holds 0x55, 0x56, 0x55 (count=3). Without the macro, count=4.

Source files
------------

// File: rtl/golden_nonce_queue.sv
// Golden-nonce capture FIFO between the hash core and host readout.
// First-word-fall-through head register, count-based full/empty, and a
// saturating counter of matches lost to a full queue.
// Optional GNQ_DEDUP_EN: drop repeated matches carrying the last seen nonce.
module golden_nonce_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          hash_clk,
    input  logic          reset,
    input  logic          match_in,
    input  logic [31:0]   nonce_in,
    output logic          out_valid,
    output logic [31:0]   out_nonce,
    input  logic          out_ack,
    output logic [AW:0]   count,
    output logic          full,
    output logic [7:0]    overflow_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          pop_c;
    logic          dup_c;
    logic          push_c;
    logic          drop_c;
    logic [AW-1:0] rd_next_c;
    logic [CW-1:0] count_next_c;
    logic [31:0]   head_next_c;

`ifdef GNQ_DEDUP_EN
    logic [31:0]   last_nonce;
    logic          last_valid;
`endif

    // Push/pop decode and next head/count computation
    always_comb begin
        pop_c        = out_ack && out_valid;
        dup_c        = 1'b0;
`ifdef GNQ_DEDUP_EN
        dup_c        = last_valid && (nonce_in == last_nonce);
`endif
        push_c       = match_in && !dup_c && (!full || pop_c);
        drop_c       = match_in && !dup_c && full && !pop_c;
        rd_next_c    = pop_c ? rd_ptr + AW'(1) : rd_ptr;
        count_next_c = count;
        if (push_c && !pop_c) begin
            count_next_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_next_c = count - CW'(1);
        end
        // Head comes straight from nonce_in when the pushed entry is the only one left
        head_next_c = out_nonce;
        if (push_c && (count == CW'(pop_c))) begin
            head_next_c = nonce_in;
        end else if (count_next_c != CW'(0)) begin
            head_next_c = mem[rd_next_c];
        end
    end

    // Nonce storage; contents need no reset
    always_ff @(posedge hash_clk) begin
        if (!reset && push_c) begin
            mem[wr_ptr] <= nonce_in;
        end
    end

    // Pointers, occupancy, registered status and head output
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            out_valid    <= 1'b0;
            out_nonce    <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr    <= rd_next_c;
            count     <= count_next_c;
            full      <= (count_next_c == CW'(DEPTH));
            out_valid <= (count_next_c != CW'(0));
            out_nonce <= head_next_c;
            if (drop_c && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

`ifdef GNQ_DEDUP_EN
    // Remember the last non-duplicate nonce, whether queued or dropped for capacity
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            last_nonce <= '0;
            last_valid <= 1'b0;
        end else if (match_in && !dup_c) begin
            last_nonce <= nonce_in;
            last_valid <= 1'b1;
        end
    end
`endif

endmodule
